f4_stream_reader: RTL
=====================

# f4_stream_reader

Read-side sequencer for the F4 (S4 pooling output) feature-map bank: 16 channels of 16-bit words sharing one read address. On `start` it walks addresses 0..DEPTH-1, captures all 16 channel words per address, and serializes them onto a valid/ready stream feeding the F5 fully-connected layer. It accounts for the block-RAM read latency and stalls cleanly on downstream backpressure. It sits between the F4 RAM read port and the F5 input.

## Interface
- `DEPTH`, default 25: words per channel (5x5 map); legal range 1..128.
- `RD_LAT`, default 1: RAM read latency in cycles, from `f4_raddr` driven to `f4_N_rdata` valid; legal range 1..3.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `start`  in  1  one-cycle request to stream the whole bank.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse after the final beat is accepted.
- `f4_raddr`  out  7  shared read address to all 16 channel RAMs.
- `f4_1_rdata` .. `f4_16_rdata`  in  16 each  channel read data.
- `f5_data`  out  16  stream payload.
- `f5_valid`  out  1  payload valid.
- `f5_ready`  in  1  consumer accepts when high together with `f5_valid`.
- `f5_ch`  out  4  channel index of the current beat (0 = channel 1).
- `f5_pos`  out  7  address (map position) of the current beat.
- `f5_last`  out  1  high on the final beat (`pos` = DEPTH-1, `ch` = 15).

## Operation
- FSM states: IDLE, RD, LD, SEND, DONE.
- IDLE: `start` = 1 → RD with `addr` = 0 and `busy` = 1. `start` is ignored in every other state.
- RD: `f4_raddr` = `addr` and held. Stays RD_LAT cycles, counted by a wait counter, then goes to LD.
- LD: one cycle. All 16 `rdata` inputs are latched into a 16×16 buffer at the end of the cycle. `ch` is cleared to 0. Next state is SEND.
- SEND: `f5_data` = buf[`ch`], `f5_valid` = 1.
  - On handshake (`f5_valid` & `f5_ready`) with `ch` < 15: `ch` increments.
  - On handshake with `ch` = 15 and `addr` < DEPTH-1: `addr` increments, next state RD.
  - On handshake with `ch` = 15 and `addr` = DEPTH-1: next state DONE.
- DONE: one cycle. `done` = 1 and `busy` drops at the end of the cycle. Next state is IDLE.
- Beat order is position-major: beat index = pos·16 + ch, for DEPTH·16 beats in total (400 by default).
- While `f5_valid` = 1 and `f5_ready` = 0, `f5_data`, `f5_ch`, `f5_pos` and `f5_last` hold stable. `f5_valid` never drops without a handshake, except on `rst`.
- `f4_raddr` changes only on entry to RD. It holds its last value in all other states.
- Reset values: `f4_raddr` = 0, `busy` = 0, `done` = 0, `f5_valid` = 0, `f5_data` = 0, `f5_ch` = 0, `f5_pos` = 0, `f5_last` = 0. FSM goes to IDLE and `buf` clears.
- Reset asserted mid-stream aborts immediately. No `done` is produced. A later `start` restarts from address 0.
- A `start` in the same cycle as DONE is ignored. A new `start` is accepted only in IDLE.

## Timing
- `start` sampled at edge E0 → RD occupies cycles E0..E0+RD_LAT, LD the next cycle, and the first `f5_valid` appears after edge E0+RD_LAT+1.
  - With RD_LAT = 1, `f5_valid` is high 2 cycles after the start cycle.
- Per address: RD_LAT+1 overhead cycles plus 16 beats.
- Full bank with `f5_ready` held at 1: DEPTH·(16+RD_LAT+1) cycles from the first RD cycle to the last beat. That is 450 cycles at the defaults.
- `done` is high in the cycle after the last handshake. `busy` is low in the following cycle.
- All outputs are registered. There are no combinational paths from `f5_ready` or `start` to outputs.

## Test plan
- RAM model with word = {ch[3:0], 5'b0, pos[6:0]}, RD_LAT = 1, `f5_ready` = 1, pulse `start` → 400 beats in order; beat k has `f5_data` = {k%16, 0, k/16}; `f5_last` only on beat 399; `done` 1 cycle after; 450 cycles from first RD to last beat.
- Random `f5_ready` (50%) → identical 400-beat sequence; payload and tags stable during every stall; no beat dropped or duplicated.
- RD_LAT = 3 with a 3-cycle RAM model → correct data; 20 cycles per address with ready = 1; `f4_raddr` held for 3 cycles in RD.
- `start` re-pulsed during busy and on the DONE cycle → ignored; exactly one stream and one `done`.
- `rst` asserted at beat 137 → `f5_valid` and `busy` are 0 immediately; no `done`. A fresh `start` then streams all 400 beats from pos 0, ch 0.
- DEPTH = 1 → 16 beats, `f5_last` on ch 15, then `done`.

Source files
------------

// File: rtl/f4_stream_reader_if.sv
// f4_stream_reader_if: F4 RAM read port plus F5 valid/ready stream bundle.
interface f4_stream_reader_if;
  logic start, busy, done;
  logic [6:0] f4_raddr;
  logic [15:0] f4_1_rdata, f4_2_rdata, f4_3_rdata, f4_4_rdata, f4_5_rdata, f4_6_rdata, f4_7_rdata, f4_8_rdata;
  logic [15:0] f4_9_rdata, f4_10_rdata, f4_11_rdata, f4_12_rdata, f4_13_rdata, f4_14_rdata, f4_15_rdata, f4_16_rdata;
  logic [15:0] f5_data;
  logic f5_valid, f5_ready, f5_last;
  logic [3:0] f5_ch;
  logic [6:0] f5_pos;
  modport master (
    input start, f5_ready,
    input f4_1_rdata, f4_2_rdata, f4_3_rdata, f4_4_rdata, f4_5_rdata, f4_6_rdata, f4_7_rdata, f4_8_rdata,
    input f4_9_rdata, f4_10_rdata, f4_11_rdata, f4_12_rdata, f4_13_rdata, f4_14_rdata, f4_15_rdata, f4_16_rdata,
    output busy, done, f4_raddr, f5_data, f5_valid, f5_ch, f5_pos, f5_last
  );
  modport slave (
    output start, f5_ready,
    output f4_1_rdata, f4_2_rdata, f4_3_rdata, f4_4_rdata, f4_5_rdata, f4_6_rdata, f4_7_rdata, f4_8_rdata,
    output f4_9_rdata, f4_10_rdata, f4_11_rdata, f4_12_rdata, f4_13_rdata, f4_14_rdata, f4_15_rdata, f4_16_rdata,
    input busy, done, f4_raddr, f5_data, f5_valid, f5_ch, f5_pos, f5_last
  );
endinterface

// File: rtl/f4_stream_reader.sv
// f4_stream_reader: walks the 16-channel F4 bank and serializes it position-major onto the F5 stream.
module f4_stream_reader #(
  parameter int DEPTH  = 25,
  parameter int RD_LAT = 1
) (
  input logic clk,
  input logic rst,
  f4_stream_reader_if.master bus
);
  localparam logic [6:0] LAST_POS  = 7'(DEPTH - 1);
  localparam logic [1:0] LAST_WAIT = 2'(RD_LAT - 1);
  typedef enum logic [2:0] {IDLE, RD, LD, SEND, DONE} state_t;
  state_t state, state_d;
  logic [6:0] addr, addr_d;
  logic [3:0] ch, ch_d;
  logic [1:0] wcnt, wcnt_d;
  logic [15:0][15:0] rdata, buf_q;
  logic hs;
  assign rdata = {bus.f4_16_rdata, bus.f4_15_rdata, bus.f4_14_rdata, bus.f4_13_rdata,
                  bus.f4_12_rdata, bus.f4_11_rdata, bus.f4_10_rdata, bus.f4_9_rdata,
                  bus.f4_8_rdata, bus.f4_7_rdata, bus.f4_6_rdata, bus.f4_5_rdata,
                  bus.f4_4_rdata, bus.f4_3_rdata, bus.f4_2_rdata, bus.f4_1_rdata};
  assign hs = (state == SEND) & bus.f5_ready;
  // addr only moves on entry to RD, so it doubles as the held RAM address
  assign bus.f4_raddr = addr;
  assign bus.f5_pos = addr;
  assign bus.f5_ch = ch;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_d;
  always_comb begin
    state_d = state;
    addr_d = addr;
    ch_d = ch;
    wcnt_d = wcnt;
    case (state)
      IDLE: if (bus.start) begin
        state_d = RD;
        addr_d = '0;
        wcnt_d = '0;
      end
      RD: begin
        wcnt_d = wcnt + 2'd1;
        state_d = (wcnt == LAST_WAIT) ? LD : RD;
      end
      LD: begin
        ch_d = '0;
        state_d = SEND;
      end
      SEND: if (hs) begin
        if (ch != 4'd15) ch_d = ch + 4'd1;
        else if (addr != LAST_POS) begin
          addr_d = addr + 7'd1;
          wcnt_d = '0;
          state_d = RD;
        end else state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      addr <= '0;
      ch <= '0;
      wcnt <= '0;
      buf_q <= '0;
      bus.f5_data <= '0;
      bus.f5_valid <= 1'b0;
      bus.f5_last <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      addr <= addr_d;
      ch <= ch_d;
      wcnt <= wcnt_d;
      if (state == LD) buf_q <= rdata;
      // the first beat bypasses the buffer because it is loaded on the same edge
      if (state_d == SEND) bus.f5_data <= (state == LD) ? rdata[0] : buf_q[ch_d];
      bus.f5_valid <= state_d == SEND;
      bus.f5_last <= (state_d == SEND) && (addr_d == LAST_POS) && (ch_d == 4'd15);
      bus.busy <= state_d != IDLE;
      bus.done <= state_d == DONE;
    end
endmodule
